// File: rtl/vga_pkg.sv
// Shared 640x480 VGA geometry and colour constants.
// Used by the sync generator and by the graphics/text/mux blocks, so every
// consumer decodes pix_x/pix_y against the same timing.
// No ports (package).
package vga_pkg;

    // Horizontal timing, in pixels
    localparam int VGA_H_DISPLAY = 640;
    localparam int VGA_H_FP      = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BP      = 48;
    localparam int VGA_H_TOTAL   = VGA_H_DISPLAY + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    // Vertical timing, in lines
    localparam int VGA_V_DISPLAY = 480;
    localparam int VGA_V_FP      = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BP      = 33;
    localparam int VGA_V_TOTAL   = VGA_V_DISPLAY + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    typedef logic [9:0] coord_t;
    typedef logic [2:0] rgb_t;

    // 3-bit colours, bit order {R,G,B}
    localparam rgb_t RGB_BLACK   = 3'b000;
    localparam rgb_t RGB_BLUE    = 3'b001;
    localparam rgb_t RGB_GREEN   = 3'b010;
    localparam rgb_t RGB_CYAN    = 3'b011;
    localparam rgb_t RGB_RED     = 3'b100;
    localparam rgb_t RGB_MAGENTA = 3'b101;
    localparam rgb_t RGB_YELLOW  = 3'b110;
    localparam rgb_t RGB_WHITE   = 3'b111;

endpackage

// File: rtl/vga_pixel_div.sv
// Pixel clock-enable generator.
// Ports:
//   i_clk    - system clock
//   i_reset  - asynchronous active-high reset
//   o_p_tick - registered one-clk pulse, once every CLK_DIV clocks
module vga_pixel_div #(
    parameter int CLK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    output logic o_p_tick
);

    localparam logic [3:0] CNT_LAST = 4'(CLK_DIV - 1);

    logic [3:0] r_cnt;
    logic       r_tick;

    // The tick is registered from the counter's terminal value, so the first
    // tick lands CLK_DIV clocks after reset release (every clock when CLK_DIV=1).
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= (r_cnt == CNT_LAST) ? 4'd0 : r_cnt + 4'd1;
            r_tick <= (r_cnt == CNT_LAST);
        end
    end

    assign o_p_tick = r_tick;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator and pin driver.
// Produces pixel enable, live pixel coordinates, video_on and frame_tick for
// the graphics blocks, and drives registered hsync/vsync/rgb to the connector,
// all lagging pix_x/pix_y by exactly one pixel.
// Ports:
//   clk, reset  - system clock, asynchronous active-high reset
//   rgb_in      - colour for the current pix_x/pix_y
//   p_tick      - one-clk pixel enable
//   pix_x/pix_y - current counts, blanking included
//   video_on    - visible-area flag for the current counts
//   frame_tick  - one-clk pulse on the last pixel of the frame
//   hsync/vsync - registered sync to pins
//   rgb_out     - registered, blank-gated colour to pins
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int   CLK_DIV     = 2,
    parameter int   H_DISPLAY   = VGA_H_DISPLAY,
    parameter int   H_FP        = VGA_H_FP,
    parameter int   H_SYNC      = VGA_H_SYNC,
    parameter int   H_BP        = VGA_H_BP,
    parameter int   V_DISPLAY   = VGA_V_DISPLAY,
    parameter int   V_FP        = VGA_V_FP,
    parameter int   V_SYNC      = VGA_V_SYNC,
    parameter int   V_BP        = VGA_V_BP,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] rgb_in,
    output logic       p_tick,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       video_on,
    output logic       frame_tick,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] rgb_out
);

    localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

    localparam coord_t H_LAST       = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST       = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS        = coord_t'(H_DISPLAY);
    localparam coord_t V_VIS        = coord_t'(V_DISPLAY);
    localparam coord_t H_SYNC_FIRST = coord_t'(H_DISPLAY + H_FP);
    localparam coord_t H_SYNC_LAST  = coord_t'(H_DISPLAY + H_FP + H_SYNC - 1);
    localparam coord_t V_SYNC_FIRST = coord_t'(V_DISPLAY + V_FP);
    localparam coord_t V_SYNC_LAST  = coord_t'(V_DISPLAY + V_FP + V_SYNC - 1);

    logic   w_p_tick;
    logic   w_x_last;
    logic   w_y_last;
    logic   w_video_on;
    logic   w_hsync_act;
    logic   w_vsync_act;

    coord_t r_x;
    coord_t r_y;
    logic   r_hsync;
    logic   r_vsync;
    rgb_t   r_rgb;

    vga_pixel_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_div (
        .i_clk    (clk),
        .i_reset  (reset),
        .o_p_tick (w_p_tick)
    );

    assign w_x_last    = (r_x == H_LAST);
    assign w_y_last    = (r_y == V_LAST);
    assign w_video_on  = (r_x < H_VIS) && (r_y < V_VIS);
    assign w_hsync_act = (r_x >= H_SYNC_FIRST) && (r_x <= H_SYNC_LAST);
    assign w_vsync_act = (r_y >= V_SYNC_FIRST) && (r_y <= V_SYNC_LAST);

    // Raster counters: x wraps at end of line, y wraps together with x on the
    // last line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_p_tick) begin
            if (w_x_last) begin
                r_x <= '0;
                r_y <= w_y_last ? coord_t'(0) : r_y + coord_t'(1);
            end else begin
                r_x <= r_x + coord_t'(1);
            end
        end
    end

    // Pin register: samples the pre-advance counts, so the pins sit exactly
    // one pixel behind pix_x/pix_y and stay aligned with each other.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hsync <= ~SYNC_ACTIVE;
            r_vsync <= ~SYNC_ACTIVE;
            r_rgb   <= RGB_BLACK;
        end else if (w_p_tick) begin
            r_hsync <= w_hsync_act ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_vsync <= w_vsync_act ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_rgb   <= w_video_on ? rgb_in : RGB_BLACK;
        end
    end

    assign p_tick     = w_p_tick;
    assign pix_x      = r_x;
    assign pix_y      = r_y;
    assign video_on   = w_video_on;
    assign frame_tick = w_p_tick && w_x_last && w_y_last;
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign rgb_out    = r_rgb;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: default geometry, CLK_DIV=1, and a small
// geometry with active-high sync so full frames fit in a short run.
module tb_vga_sync_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] rgb_in;

    int checks   = 0;
    int failures = 0;

    // default instance
    logic       d_p_tick, d_video_on, d_frame_tick, d_hsync, d_vsync;
    logic [9:0] d_pix_x, d_pix_y;
    logic [2:0] d_rgb_out;
    // CLK_DIV=1 instance
    logic       o1_p_tick, o1_video_on, o1_frame_tick, o1_hsync, o1_vsync;
    logic [9:0] o1_pix_x, o1_pix_y;
    logic [2:0] o1_rgb_out;
    // small geometry: H 8/2/3/2 (15), V 4/1/2/1 (8), active-high sync
    logic       s_p_tick, s_video_on, s_frame_tick, s_hsync, s_vsync;
    logic [9:0] s_pix_x, s_pix_y;
    logic [2:0] s_rgb_out;

    always #5 clk = ~clk;

    vga_sync_gen u_dut (
        .clk(clk), .reset(reset), .rgb_in(rgb_in), .p_tick(d_p_tick),
        .pix_x(d_pix_x), .pix_y(d_pix_y), .video_on(d_video_on),
        .frame_tick(d_frame_tick), .hsync(d_hsync), .vsync(d_vsync),
        .rgb_out(d_rgb_out)
    );

    vga_sync_gen #(.CLK_DIV(1)) u_div1 (
        .clk(clk), .reset(reset), .rgb_in(rgb_in), .p_tick(o1_p_tick),
        .pix_x(o1_pix_x), .pix_y(o1_pix_y), .video_on(o1_video_on),
        .frame_tick(o1_frame_tick), .hsync(o1_hsync), .vsync(o1_vsync),
        .rgb_out(o1_rgb_out)
    );

    vga_sync_gen #(
        .CLK_DIV(2), .H_DISPLAY(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_DISPLAY(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_ACTIVE(1'b1)
    ) u_small (
        .clk(clk), .reset(reset), .rgb_in(rgb_in), .p_tick(s_p_tick),
        .pix_x(s_pix_x), .pix_y(s_pix_y), .video_on(s_video_on),
        .frame_tick(s_frame_tick), .hsync(s_hsync), .vsync(s_vsync),
        .rgb_out(s_rgb_out)
    );

    // Leaves reset released at 1 ns after a rising edge.
    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        rgb_in = 3'b101;
        reset  = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (d_pix_x !== 10'd0) begin failures++; $display("FAIL rst_pix_x got=%0d exp=0", d_pix_x); end
        checks++; if (d_pix_y !== 10'd0) begin failures++; $display("FAIL rst_pix_y got=%0d exp=0", d_pix_y); end
        checks++; if (d_hsync !== 1'b1) begin failures++; $display("FAIL rst_hsync got=%b exp=1", d_hsync); end
        checks++; if (d_vsync !== 1'b1) begin failures++; $display("FAIL rst_vsync got=%b exp=1", d_vsync); end
        checks++; if (d_rgb_out !== 3'b000) begin failures++; $display("FAIL rst_rgb got=%b exp=000", d_rgb_out); end
        checks++; if (d_p_tick !== 1'b0) begin failures++; $display("FAIL rst_p_tick got=%b exp=0", d_p_tick); end
        checks++; if (d_frame_tick !== 1'b0) begin failures++; $display("FAIL rst_frame_tick got=%b exp=0", d_frame_tick); end
        checks++; if (d_video_on !== 1'b1) begin failures++; $display("FAIL rst_video_on got=%b exp=1", d_video_on); end
        checks++; if (s_hsync !== 1'b0 || s_vsync !== 1'b0) begin failures++; $display("FAIL rst_small_sync got=%b%b exp=00", s_hsync, s_vsync); end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (d_p_tick !== 1'b0) begin failures++; $display("FAIL tick_early got=%b exp=0", d_p_tick); end
        checks++; if (o1_p_tick !== 1'b1) begin failures++; $display("FAIL div1_first_tick got=%b exp=1", o1_p_tick); end
        @(posedge clk); #1;
        checks++; if (d_p_tick !== 1'b1) begin failures++; $display("FAIL tick_first got=%b exp=1", d_p_tick); end
        checks++; if (d_pix_x !== 10'd0 || d_pix_y !== 10'd0) begin failures++; $display("FAIL tick_first_xy got=%0d,%0d exp=0,0", d_pix_x, d_pix_y); end
        @(posedge clk); #1;
        checks++; if (d_p_tick !== 1'b0) begin failures++; $display("FAIL tick_width got=%b exp=0", d_p_tick); end
        checks++; if (d_pix_x !== 10'd1) begin failures++; $display("FAIL tick_advance got=%0d exp=1", d_pix_x); end
        @(posedge clk); #1;
        checks++; if (d_p_tick !== 1'b1) begin failures++; $display("FAIL tick_period got=%b exp=1", d_p_tick); end
    endtask

    task automatic test_line();
        int hs_low, first_low, px, ex, ey;
        logic exp_hs;
        logic [2:0] exp_rgb;
        hs_low = 0; first_low = -1;
        rgb_in = 3'b101;
        do_reset();
        repeat (2) @(posedge clk); #1;
        for (int i = 0; i <= 800; i++) begin
            if (i > 0) begin repeat (2) @(posedge clk); #1; end
            ex = i % 800; ey = i / 800;
            checks++; if (d_p_tick !== 1'b1) begin failures++; $display("FAIL line_tick i=%0d got=%b exp=1", i, d_p_tick); end
            checks++; if (int'(d_pix_x) !== ex) begin failures++; $display("FAIL line_pix_x i=%0d got=%0d exp=%0d", i, d_pix_x, ex); end
            checks++; if (int'(d_pix_y) !== ey) begin failures++; $display("FAIL line_pix_y i=%0d got=%0d exp=%0d", i, d_pix_y, ey); end
            checks++; if (d_video_on !== (ex < 640)) begin failures++; $display("FAIL line_video_on i=%0d got=%b", i, d_video_on); end
            checks++; if (d_frame_tick !== 1'b0) begin failures++; $display("FAIL line_frame_tick i=%0d got=%b exp=0", i, d_frame_tick); end
            if (i > 0) begin
                px = i - 1;
                exp_hs  = (px >= 656 && px <= 751) ? 1'b0 : 1'b1;
                exp_rgb = (px < 640) ? 3'b101 : 3'b000;
                checks++; if (d_hsync !== exp_hs) begin failures++; $display("FAIL line_hsync i=%0d got=%b exp=%b", i, d_hsync, exp_hs); end
                checks++; if (d_rgb_out !== exp_rgb) begin failures++; $display("FAIL line_rgb i=%0d got=%b exp=%b", i, d_rgb_out, exp_rgb); end
                checks++; if (d_vsync !== 1'b1) begin failures++; $display("FAIL line_vsync i=%0d got=%b exp=1", i, d_vsync); end
                if (d_hsync === 1'b0) begin
                    hs_low++;
                    if (first_low < 0) first_low = i;
                end
            end
        end
        checks++; if (hs_low !== 96) begin failures++; $display("FAIL line_hsync_width got=%0d exp=96", hs_low); end
        checks++; if (first_low !== 657) begin failures++; $display("FAIL line_hsync_first got=%0d exp=657", first_low); end
    endtask

    task automatic test_rgb_capture();
        logic [2:0] pat, prev;
        prev = 3'b000;
        do_reset();
        rgb_in = 3'b111;
        repeat (2) @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
            pat = ~(3'(i) ^ 3'b010);
            checks++; if (d_p_tick !== 1'b1) begin failures++; $display("FAIL cap_tick i=%0d got=%b exp=1", i, d_p_tick); end
            if (i > 0) begin
                checks++; if (d_rgb_out !== prev) begin failures++; $display("FAIL cap_rgb i=%0d got=%b exp=%b", i, d_rgb_out, prev); end
            end
            rgb_in = pat;
            @(posedge clk); #1;
            rgb_in = ~pat;
            checks++; if (d_rgb_out !== pat) begin failures++; $display("FAIL cap_rgb_hold i=%0d got=%b exp=%b", i, d_rgb_out, pat); end
            @(posedge clk); #1;
            prev = pat;
        end
    endtask

    task automatic test_clkdiv1();
        int hs_low, first_low, ex, ey;
        hs_low = 0; first_low = -1;
        do_reset();
        for (int n = 0; n <= 800; n++) begin
            @(posedge clk); #1;
            ex = n % 800; ey = n / 800;
            checks++; if (o1_p_tick !== 1'b1) begin failures++; $display("FAIL div1_tick n=%0d got=%b exp=1", n, o1_p_tick); end
            checks++; if (int'(o1_pix_x) !== ex || int'(o1_pix_y) !== ey) begin failures++; $display("FAIL div1_xy n=%0d got=%0d,%0d exp=%0d,%0d", n, o1_pix_x, o1_pix_y, ex, ey); end
            if (n > 0 && o1_hsync === 1'b0) begin
                hs_low++;
                if (first_low < 0) first_low = n;
            end
        end
        checks++; if (hs_low !== 96) begin failures++; $display("FAIL div1_hsync_width got=%0d exp=96", hs_low); end
        checks++; if (first_low !== 657) begin failures++; $display("FAIL div1_hsync_first got=%0d exp=657", first_low); end
    endtask

    task automatic test_frame();
        int ex, ey, px, py, frames, vs_hi, hs_hi, max_y;
        logic exp_hs, exp_vs;
        logic [2:0] exp_rgb;
        frames = 0; vs_hi = 0; hs_hi = 0; max_y = 0;
        rgb_in = 3'b101;
        do_reset();
        repeat (2) @(posedge clk); #1;
        for (int i = 0; i <= 240; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
                checks++; if (s_frame_tick !== 1'b0) begin failures++; $display("FAIL frm_tick_offclk i=%0d got=%b exp=0", i, s_frame_tick); end
                @(posedge clk); #1;
            end
            ex = i % 15; ey = (i / 15) % 8;
            if (int'(s_pix_y) > max_y) max_y = int'(s_pix_y);
            checks++; if (int'(s_pix_x) !== ex || int'(s_pix_y) !== ey) begin failures++; $display("FAIL frm_xy i=%0d got=%0d,%0d exp=%0d,%0d", i, s_pix_x, s_pix_y, ex, ey); end
            checks++; if (s_video_on !== (ex < 8 && ey < 4)) begin failures++; $display("FAIL frm_video_on i=%0d got=%b", i, s_video_on); end
            checks++; if (s_frame_tick !== (ex == 14 && ey == 7)) begin failures++; $display("FAIL frm_frame_tick i=%0d got=%b", i, s_frame_tick); end
            if (s_frame_tick === 1'b1) frames++;
            if (i > 0) begin
                px = (i - 1) % 15; py = ((i - 1) / 15) % 8;
                exp_hs  = (px >= 10 && px <= 12);
                exp_vs  = (py >= 5 && py <= 6);
                exp_rgb = (px < 8 && py < 4) ? 3'b101 : 3'b000;
                checks++; if (s_hsync !== exp_hs) begin failures++; $display("FAIL frm_hsync i=%0d got=%b exp=%b", i, s_hsync, exp_hs); end
                checks++; if (s_vsync !== exp_vs) begin failures++; $display("FAIL frm_vsync i=%0d got=%b exp=%b", i, s_vsync, exp_vs); end
                checks++; if (s_rgb_out !== exp_rgb) begin failures++; $display("FAIL frm_rgb i=%0d got=%b exp=%b", i, s_rgb_out, exp_rgb); end
                if (i <= 120 && s_vsync === 1'b1) vs_hi++;
                if (i <= 120 && s_hsync === 1'b1) hs_hi++;
            end
        end
        checks++; if (frames !== 2) begin failures++; $display("FAIL frm_count got=%0d exp=2", frames); end
        checks++; if (vs_hi !== 30) begin failures++; $display("FAIL frm_vsync_width got=%0d exp=30", vs_hi); end
        checks++; if (hs_hi !== 24) begin failures++; $display("FAIL frm_hsync_total got=%0d exp=24", hs_hi); end
        checks++; if (max_y !== 7) begin failures++; $display("FAIL frm_max_y got=%0d exp=7", max_y); end
    endtask

    task automatic test_midframe_reset();
        rgb_in = 3'b101;
        do_reset();
        repeat (2 + 2 * 35) @(posedge clk);
        #1;
        checks++; if (s_pix_x !== 10'd5 || s_pix_y !== 10'd2) begin failures++; $display("FAIL mid_pre_xy got=%0d,%0d exp=5,2", s_pix_x, s_pix_y); end
        checks++; if (s_rgb_out !== 3'b101) begin failures++; $display("FAIL mid_pre_rgb got=%b exp=101", s_rgb_out); end
        checks++; if (d_pix_x !== 10'd35) begin failures++; $display("FAIL mid_pre_dx got=%0d exp=35", d_pix_x); end
        #1;
        reset = 1'b1;
        #1;
        checks++; if (s_pix_x !== 10'd0 || s_pix_y !== 10'd0) begin failures++; $display("FAIL mid_async_xy got=%0d,%0d exp=0,0", s_pix_x, s_pix_y); end
        checks++; if (s_rgb_out !== 3'b000) begin failures++; $display("FAIL mid_async_rgb got=%b exp=000", s_rgb_out); end
        checks++; if (s_hsync !== 1'b0 || s_vsync !== 1'b0) begin failures++; $display("FAIL mid_async_sync got=%b%b exp=00", s_hsync, s_vsync); end
        checks++; if (s_p_tick !== 1'b0 || s_frame_tick !== 1'b0) begin failures++; $display("FAIL mid_async_ticks got=%b%b exp=00", s_p_tick, s_frame_tick); end
        checks++; if (s_video_on !== 1'b1) begin failures++; $display("FAIL mid_async_video_on got=%b exp=1", s_video_on); end
        checks++; if (d_pix_x !== 10'd0) begin failures++; $display("FAIL mid_async_dx got=%0d exp=0", d_pix_x); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (s_p_tick !== 1'b0) begin failures++; $display("FAIL mid_rel_tick_early got=%b exp=0", s_p_tick); end
        @(posedge clk); #1;
        checks++; if (s_p_tick !== 1'b1 || s_pix_x !== 10'd0 || s_pix_y !== 10'd0) begin failures++; $display("FAIL mid_rel_first tick=%b xy=%0d,%0d exp=1 0,0", s_p_tick, s_pix_x, s_pix_y); end
        repeat (2) @(posedge clk); #1;
        checks++; if (s_pix_x !== 10'd1 || s_pix_y !== 10'd0) begin failures++; $display("FAIL mid_rel_resume got=%0d,%0d exp=1,0", s_pix_x, s_pix_y); end
    endtask

    initial begin
        reset  = 1'b0;
        rgb_in = 3'b000;
        #2;
        test_reset();
        test_line();
        test_rgb_capture();
        test_clkdiv1();
        test_frame();
        test_midframe_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Produces the pixel timing that every graphics block consumes: the pixel clock-enable, the live pixel coordinates pix_x/pix_y, video_on and the frame tick.
- Registers the incoming graphics colour and gates it to black during blanking.
- Drives the VGA connector's hsync/vsync/rgb, all aligned to one pixel latency.
- Sits at the top level between the board VGA pins and the graphics/text/mux blocks.

Parameters:
- CLK_DIV, 2, system clocks per pixel (2 gives 25 MHz from 50 MHz); legal range 1..16.
- H_DISPLAY, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync pulse width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_DISPLAY, 480, visible lines.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vsync pulse width in lines.
- V_BP, 33, vertical back porch in lines.
- SYNC_ACTIVE, 0, level of hsync/vsync while asserted (0 = negative polarity).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- rgb_in  input  3  colour for the current pix_x/pix_y, from the graphics mux
- p_tick  output  1  one-clk pixel enable, every CLK_DIV clocks
- pix_x  output  10  current horizontal count, 0..H_TOTAL-1, blanking included
- pix_y  output  10  current vertical count, 0..V_TOTAL-1, blanking included
- video_on  output  1  high while pix_x<H_DISPLAY and pix_y<V_DISPLAY
- frame_tick  output  1  one-clk pulse at end of frame
- hsync  output  1  registered horizontal sync to pin
- vsync  output  1  registered vertical sync to pin
- rgb_out  output  3  registered, blank-gated colour to pin

Behaviour:
- H_TOTAL = H_DISPLAY+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_DISPLAY+V_FP+V_SYNC+V_BP (525). Both must be ≤1024 to fit 10 bits.
- Reset values (asynchronous): div counter=0, pix_x=0, pix_y=0, p_tick=0, frame_tick=0, hsync=vsync=~SYNC_ACTIVE, rgb_out=0. video_on=1 follows from counts 0,0.
- Divider: counter runs 0..CLK_DIV-1 and wraps. p_tick is registered and high for exactly the clk in which the counter value is CLK_DIV-1.
  - First p_tick occurs CLK_DIV clks after reset release.
  - With CLK_DIV=1, p_tick is high on every clk after the first post-reset edge.
- Counters advance only in clk cycles where p_tick=1.
  - pix_x increments. At H_TOTAL-1 it wraps to 0 and pix_y increments.
  - pix_y wraps from V_TOTAL-1 to 0 in the same cycle pix_x wraps.
  - No other wrap points exist. Counts never leave their ranges.
- pix_x/pix_y/video_on are direct register outputs with 0 latency, so consumers decode them combinationally in the same pixel. Consumers rely on pix_y reaching the blanking lines 480..524; e.g. a refresh tick is decoded at pix_y=481, pix_x=0.
- frame_tick is combinational: p_tick && pix_x==H_TOTAL-1 && pix_y==V_TOTAL-1. It is high for one clk per frame.
- Output stage updates only on p_tick, sampling the current (pre-advance) counts:
  - rgb_out <= video_on ? rgb_in : 0.
  - hsync <= SYNC_ACTIVE if H_DISPLAY+H_FP ≤ pix_x ≤ H_DISPLAY+H_FP+H_SYNC-1, else ~SYNC_ACTIVE.
  - vsync <= SYNC_ACTIVE if V_DISPLAY+V_FP ≤ pix_y ≤ V_DISPLAY+V_FP+V_SYNC-1, else ~SYNC_ACTIVE.
  - Result: pin outputs lag pix_x/pix_y by exactly one pixel and are mutually aligned.
- Default timing:
  - hsync asserted for pix_x 656..751, seen on pin one pixel later.
  - vsync asserted for pix_y 490..491 over all 800 pixels of those lines.
- Reset mid-frame forces the reset values immediately, with no wait for the frame end. Counting restarts from (0,0) after release.
- rgb_in changing between p_ticks has no effect; only the value at p_tick is captured.

Decomposition:
- Shared package vga_pkg holds the eight timing constants plus H_TOTAL/V_TOTAL, so pong_graph and the text/mux blocks use the same 640x480 geometry. The package also defines the 3-bit RGB colour constants.
- One natural sub-module, vga_pixel_div: the CLK_DIV counter producing p_tick.
- Counters, sync decode and the output register stay in vga_sync_gen.

Test Plan:
- Reset held 5 clks, then released → pix_x=0, pix_y=0, hsync=vsync=1, rgb_out=0; first p_tick 2 clks after release; p_tick period 2 clks, width 1 clk.
- Run one line, CLK_DIV=2 → pix_x walks 0..799 then 0, pix_y goes 0→1 on the wrap; hsync pin low for exactly 96 p_ticks, first low at the p_tick after pix_x=656 is sampled.
- Run full frame → frame_tick exactly once per 420000 p_ticks, coinciding with pix_x=799, pix_y=524; vsync low for exactly 1600 p_ticks (lines 490–491).
- rgb_in held at 3'b101 → rgb_out=101 for samples with pix_x<640 and pix_y<480; rgb_out=000 for pix_x 640..799 and for pix_y≥480.
- Reset asserted at pix_x=300, pix_y=200 → all outputs at reset values within the same clk, with no clock edge required; after release, counting resumes from 0,0.
- CLK_DIV=1 → p_tick continuously high; one line is 800 clks; sync widths unchanged in pixel units.
